// File: rtl/mc_resp_model.sv
// mc_resp_model: fixed-latency in-order memory responder with a response FIFO and two-way backpressure
module mc_resp_model #(
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int RAM_DEPTH       = 512,
  parameter int LATENCY         = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int STALL_SLACK     = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mc_rq_vld,
  input  logic [2:0]                 mc_rq_cmd,
  input  logic [3:0]                 mc_rq_scmd,
  input  logic [47:0]                mc_rq_vadr,
  input  logic [1:0]                 mc_rq_size,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]                mc_rq_data,
  input  logic                       mc_rq_flush,
  output logic                       mc_rq_stall,
  output logic                       mc_rs_vld,
  output logic [2:0]                 mc_rs_cmd,
  output logic [3:0]                 mc_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  output logic [63:0]                mc_rs_data,
  input  logic                       mc_rs_stall,
  output logic                       err_ovf,
  output logic                       err_cmd,
  output logic [31:0]                rd_cnt,
  output logic [31:0]                wr_cnt
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2:0]                 cmd;
    logic [3:0]                 scmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]                data;
  } ent_t;

  logic [63:0] ram [RAM_DEPTH] = '{default: '0};
  ent_t fifo_mem [FIFO_DEPTH];
  ent_t pipe_q [LATENCY];
  ent_t pipe_d [LATENCY];
  logic [LATENCY-1:0] pv_q, pv_d;
  logic [FW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ent_t rs_q, rs_d;
  logic rs_vld_q, rs_vld_d, rq_stall_q, rq_stall_d;
  logic err_ovf_q, err_ovf_d, err_cmd_q, err_cmd_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [2:0] cmd_eff;
  logic [AW-1:0] idx;
  logic [31:0] outst, outst_nx;
  logic legal, full, acc, push, pop;
  logic unused;

  assign unused = ^{mc_rq_size, mc_rq_vadr};

  always_comb begin
    cmd_eff = mc_rq_flush ? 3'd6 : mc_rq_cmd;
    legal = cmd_eff == 3'd1 || cmd_eff == 3'd2 || cmd_eff == 3'd6;
    idx = mc_rq_vadr[3 +: AW];
    // outstanding work covers both in-flight pipeline entries and queued responses
    outst = 32'($countones(pv_q)) + 32'(cnt_q);
    full = outst >= 32'(FIFO_DEPTH);
    acc = mc_rq_vld && legal && !full;
    push = pv_q[LATENCY-1];
    pop = cnt_q != '0 && !mc_rs_stall;
    pv_d = LATENCY'({pv_q, acc});
    pipe_d[0].cmd = cmd_eff == 3'd1 ? 3'd2 : cmd_eff == 3'd2 ? 3'd3 : 3'd7;
    pipe_d[0].scmd = mc_rq_scmd;
    pipe_d[0].rtnctl = mc_rq_rtnctl;
    pipe_d[0].data = cmd_eff == 3'd1 ? ram[idx] : '0;
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    wp_d = wp_q + FW'(push);
    rp_d = rp_q + FW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    outst_nx = outst + 32'(acc) - 32'(pop);
    rq_stall_d = outst_nx >= 32'(FIFO_DEPTH - STALL_SLACK);
    rs_vld_d = pop;
    rs_d = pop ? fifo_mem[rp_q] : rs_q;
    err_ovf_d = err_ovf_q | (mc_rq_vld && legal && full);
    err_cmd_d = err_cmd_q | (mc_rq_vld && !legal);
    rd_cnt_d = rd_cnt_q + 32'(acc && cmd_eff == 3'd1);
    wr_cnt_d = wr_cnt_q + 32'(acc && cmd_eff == 3'd2);
  end

  always_ff @(posedge clk) begin
    if (acc && cmd_eff == 3'd2) ram[idx] <= mc_rq_data;
    if (push) fifo_mem[wp_q] <= pipe_q[LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      pv_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rs_q <= '0;
      rs_vld_q <= 1'b0;
      rq_stall_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_cmd_q <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
      pv_q <= pv_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rs_q <= rs_d;
      rs_vld_q <= rs_vld_d;
      rq_stall_q <= rq_stall_d;
      err_ovf_q <= err_ovf_d;
      err_cmd_q <= err_cmd_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign mc_rq_stall = rq_stall_q;
  assign mc_rs_vld = rs_vld_q;
  assign mc_rs_cmd = rs_q.cmd;
  assign mc_rs_scmd = rs_q.scmd;
  assign mc_rs_rtnctl = rs_q.rtnctl;
  assign mc_rs_data = rs_q.data;
  assign err_ovf = err_ovf_q;
  assign err_cmd = err_cmd_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
endmodule

// File: tb/tb_mc_resp_model.sv
// tb_mc_resp_model: directed scenarios for mc_resp_model with a negedge response monitor
module tb_mc_resp_model;
  logic clk = 0, rst_n = 0;
  logic mc_rq_vld = 0, mc_rq_flush = 0, mc_rs_stall = 0;
  logic [2:0] mc_rq_cmd = 0;
  logic [3:0] mc_rq_scmd = 0;
  logic [47:0] mc_rq_vadr = 0;
  logic [1:0] mc_rq_size = 0;
  logic [31:0] mc_rq_rtnctl = 0;
  logic [63:0] mc_rq_data = 0;
  logic mc_rq_stall, mc_rs_vld, err_ovf, err_cmd;
  logic [2:0] mc_rs_cmd;
  logic [3:0] mc_rs_scmd;
  logic [31:0] mc_rs_rtnctl, rd_cnt, wr_cnt;
  logic [63:0] mc_rs_data;

  typedef struct {
    int e;
    logic [2:0] cmd;
    logic [3:0] scmd;
    logic [31:0] tag;
    logic [63:0] data;
  } rsp_t;

  rsp_t q[$];
  int ecnt = 0;
  int n_chk = 0, n_fail = 0, exp_rd = 0, exp_wr = 0;
  localparam logic [63:0] D0 = 64'hDEAD_BEEF_0123;

  mc_resp_model dut (
    .clk(clk), .rst_n(rst_n), .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd),
    .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size),
    .mc_rq_rtnctl(mc_rq_rtnctl), .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush),
    .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
    .mc_rs_scmd(mc_rs_scmd), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data),
    .mc_rs_stall(mc_rs_stall), .err_ovf(err_ovf), .err_cmd(err_cmd),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  always @(negedge clk) if (mc_rs_vld) q.push_back('{ecnt, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] c, input logic fl, input logic [3:0] s, input logic [47:0] a,
                     input logic [31:0] t, input logic [63:0] d, output int e);
    mc_rq_vld = 1; mc_rq_cmd = c; mc_rq_flush = fl; mc_rq_scmd = s;
    mc_rq_vadr = a; mc_rq_rtnctl = t; mc_rq_data = d;
    tick;
    e = ecnt;
    mc_rq_vld = 0; mc_rq_flush = 0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && q.size() < n; i++) tick;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    #1;
    n_chk++;
    if ({mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, mc_rq_stall, err_ovf, err_cmd, rd_cnt, wr_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: vld=%b cmd=%0d data=%h stall=%b ovf=%b cmd_err=%b rd=%0d wr=%0d, all required 0",
        mc_rs_vld, mc_rs_cmd, mc_rs_data, mc_rq_stall, err_ovf, err_cmd, rd_cnt, wr_cnt);
    end
    tick; tick;
    rst_n = 1;
    tick;
  endtask

  task automatic test_write_read;
    int ew, er;
    q.delete();
    req(3'd2, 0, 4'h1, 48'h40, 32'h55, D0, ew);
    req(3'd1, 0, 4'h2, 48'h40, 32'h66, 64'h0, er);
    exp_wr++; exp_rd++;
    wait_rsp(2, 20);
    n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d responses, want 2", q.size()); end
    n_chk++; if (q[0].e != ew + 9) begin n_fail++; $display("FAIL wr_latency: edge %0d, want %0d", q[0].e, ew + 9); end
    n_chk++; if (q[0].cmd !== 3'd3 || q[0].tag !== 32'h55) begin n_fail++; $display("FAIL wr_rsp: cmd=%0d tag=%h, want 3/55", q[0].cmd, q[0].tag); end
    n_chk++; if (q[1].e != er + 9) begin n_fail++; $display("FAIL rd_latency: edge %0d, want %0d", q[1].e, er + 9); end
    n_chk++; if (q[1].cmd !== 3'd2 || q[1].data !== D0 || q[1].tag !== 32'h66) begin
      n_fail++; $display("FAIL rd_rsp: cmd=%0d data=%h tag=%h, want 2/%h/66", q[1].cmd, q[1].data, q[1].tag, D0);
    end
    n_chk++; if (rd_cnt !== 32'(exp_rd) || wr_cnt !== 32'(exp_wr)) begin
      n_fail++; $display("FAIL wr_rd_cnt: rd=%0d wr=%0d, want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_overflow;
    int e;
    q.delete();
    mc_rs_stall = 1;
    for (int i = 0; i < 20; i++) begin
      req(3'd1, 0, 4'h0, 48'h40, 32'(i), 64'h0, e);
      n_chk++; if (mc_rq_stall !== (i >= 12)) begin n_fail++; $display("FAIL rq_stall[%0d]: got %b, want %b", i, mc_rq_stall, i >= 12); end
      n_chk++; if (err_ovf !== (i >= 16)) begin n_fail++; $display("FAIL err_ovf[%0d]: got %b, want %b", i, err_ovf, i >= 16); end
    end
    exp_rd += 16;
    mc_rs_stall = 0;
    wait_rsp(16, 40);
    n_chk++; if (q.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d responses, want 16", q.size()); end
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (q[i].tag !== 32'(i)) begin n_fail++; $display("FAIL ovf_tag[%0d]: got %0d, want %0d", i, q[i].tag, i); end
    end
    n_chk++; if (mc_rq_stall !== 1'b0 || rd_cnt !== 32'(exp_rd)) begin
      n_fail++; $display("FAIL ovf_drain: stall=%b rd=%0d, want 0/%0d", mc_rq_stall, rd_cnt, exp_rd);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    logic s;
    q.delete();
    for (int c = 0; c < 60; c++) begin
      s = c[0];
      mc_rs_stall = s;
      if (c < 10) req(3'd1, 0, 4'h0, 48'h40, 32'(100 + c), 64'h0, e);
      else tick;
      n_chk++; if (mc_rs_vld && s) begin n_fail++; $display("FAIL stall_issue[%0d]: vld=1 with stall=1, want vld=0", c); end
    end
    mc_rs_stall = 0;
    exp_rd += 10;
    n_chk++; if (q.size() != 10) begin n_fail++; $display("FAIL toggle_count: got %0d responses, want 10", q.size()); end
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (q[i].tag !== 32'(100 + i)) begin n_fail++; $display("FAIL toggle_tag[%0d]: got %0d, want %0d", i, q[i].tag, 100 + i); end
    end
  endtask

  task automatic test_read_flush_write;
    int e;
    logic [2:0] ec [4];
    logic [63:0] ed [4];
    ec = '{3'd2, 3'd7, 3'd3, 3'd7};
    ed = '{D0, 64'h0, 64'h0, 64'h0};
    q.delete();
    req(3'd1, 0, 4'h1, 48'h40, 32'hA1, 64'h0, e);
    req(3'd6, 0, 4'h2, 48'h0, 32'hA2, 64'h1234, e);
    req(3'd2, 0, 4'h3, 48'h80, 32'hA3, 64'h77, e);
    req(3'd1, 1, 4'h4, 48'h40, 32'hA4, 64'h5678, e);
    exp_rd++; exp_wr++;
    wait_rsp(4, 20);
    n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL rfw_count: got %0d responses, want 4", q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (q[i].cmd !== ec[i] || q[i].scmd !== 4'(i + 1) || q[i].data !== ed[i]) begin
        n_fail++; $display("FAIL rfw[%0d]: cmd=%0d scmd=%0d data=%h, want %0d/%0d/%h", i, q[i].cmd, q[i].scmd, q[i].data, ec[i], i + 1, ed[i]);
      end
    end
    n_chk++; if (rd_cnt !== 32'(exp_rd) || wr_cnt !== 32'(exp_wr)) begin
      n_fail++; $display("FAIL rfw_cnt: rd=%0d wr=%0d, want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_illegal;
    int e;
    q.delete();
    n_chk++; if (err_cmd !== 1'b0) begin n_fail++; $display("FAIL err_cmd_pre: got %b, want 0", err_cmd); end
    req(3'd5, 0, 4'h0, 48'h40, 32'hBB, 64'h0, e);
    repeat (15) tick;
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL illegal_rsp: got %0d responses, want 0", q.size()); end
    n_chk++; if (err_cmd !== 1'b1) begin n_fail++; $display("FAIL err_cmd: got %b, want 1", err_cmd); end
    n_chk++; if (rd_cnt !== 32'(exp_rd) || wr_cnt !== 32'(exp_wr)) begin
      n_fail++; $display("FAIL illegal_cnt: rd=%0d wr=%0d, want %0d/%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset_inflight;
    int e;
    q.delete();
    for (int i = 0; i < 6; i++) req(3'd1, 0, 4'h0, 48'h40, 32'(200 + i), 64'h0, e);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl, mc_rs_data, mc_rq_stall, err_ovf, err_cmd, rd_cnt, wr_cnt} !== '0) begin
      n_fail++; $display("FAIL async_reset: vld=%b cmd=%0d data=%h stall=%b ovf=%b cmd_err=%b rd=%0d wr=%0d, all required 0",
        mc_rs_vld, mc_rs_cmd, mc_rs_data, mc_rq_stall, err_ovf, err_cmd, rd_cnt, wr_cnt);
    end
    tick; tick;
    rst_n = 1;
    repeat (20) tick;
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL stale_rsp: got %0d responses, want 0", q.size()); end
    req(3'd1, 0, 4'h0, 48'h40, 32'h99, 64'h0, e);
    wait_rsp(1, 20);
    n_chk++; if (q.size() != 1 || q[0].data !== D0 || q[0].tag !== 32'h99) begin
      n_fail++; $display("FAIL ram_keep: n=%0d data=%h tag=%h, want 1/%h/99", q.size(), q[0].data, q[0].tag, D0);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_overflow;
    test_back_to_back;
    test_read_flush_write;
    test_illegal;
    test_reset_inflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_resp_model.md
Name: mc_resp_model

Overview:
- Synthesizable memory-controller responder for one MC port.
- Sits opposite the simulator core's request interface: it accepts mc_rq_* requests and returns mc_rs_* responses after a fixed, parameterized latency.
- Supports backpressure in both directions, so bench and emulation runs see realistic in-order memory timing.
- Backing store is an internal 64-bit word RAM.

Parameters:
- MC_RTNCTL_WIDTH, 32: width of the rtnctl tag that is echoed back.
- RAM_DEPTH, 512: number of 64-bit words; must be a power of 2.
- LATENCY, 8: request-to-FIFO pipeline depth in cycles; must be at least 1.
- FIFO_DEPTH, 16: response FIFO entries; must be a power of 2 and at least 4.
- STALL_SLACK, 3: number of requests still guaranteed to be accepted after mc_rq_stall rises.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mc_rq_vld  in  1  request valid
- mc_rq_cmd  in  3  1=read, 2=write, 6=flush; any other value is illegal
- mc_rq_scmd  in  4  subcommand, echoed in the response
- mc_rq_vadr  in  48  byte address; word index = vadr[3 +: log2(RAM_DEPTH)]
- mc_rq_size  in  2  ignored; every access is 64-bit
- mc_rq_rtnctl  in  MC_RTNCTL_WIDTH  tag, echoed in the response
- mc_rq_data  in  64  write data
- mc_rq_flush  in  1  alias of flush; treated as cmd=6 when mc_rq_vld=1
- mc_rq_stall  out  1  advisory request backpressure
- mc_rs_vld  out  1  response valid
- mc_rs_cmd  out  3  2=read data, 3=write complete, 7=flush complete
- mc_rs_scmd  out  4  echoed scmd
- mc_rs_rtnctl  out  MC_RTNCTL_WIDTH  echoed tag
- mc_rs_data  out  64  read data; 0 for all non-read responses
- mc_rs_stall  in  1  response backpressure from the requester
- err_ovf  out  1  sticky; set when a request is dropped because there is no slot
- err_cmd  out  1  sticky; set on an illegal cmd
- rd_cnt  out  32  reads accepted, wraps
- wr_cnt  out  32  writes accepted, wraps

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pipeline valid bits, FIFO pointers and count are cleared.
  - mc_rs_vld=0, mc_rs_cmd=0, mc_rs_scmd=0, mc_rs_rtnctl=0, mc_rs_data=0.
  - mc_rq_stall=0, err_ovf=0, err_cmd=0, rd_cnt=0, wr_cnt=0.
  - RAM contents are not reset; RAM is zero-initialised at time 0 only.
  - Reset mid-operation discards every in-flight request silently.
- Accept: at most one request per cycle; a request is accepted on any clk edge with mc_rq_vld=1.
  - mc_rq_stall does not gate acceptance.
  - Illegal cmd: request is dropped, err_cmd is set, no response is generated.
- Write: RAM[idx] <= mc_rq_data at the accepting edge.
- Read: RAM[idx] is sampled at the accepting edge.
  - A read in the cycle after a write to the same idx returns the new data.
  - Only one request per cycle exists, so there is no same-cycle read/write collision.
- Pipeline: the accepted entry {cmd_rs, scmd, rtnctl, data} shifts through LATENCY registered stages, then is pushed into the FIFO.
  - The pipeline never stalls.
  - Ordering is strictly in-order for all command types.
- Occupancy: outst = (pipeline valid count) + fifo_count.
  - mc_rq_stall is registered: mc_rq_stall <= (outst_next >= FIFO_DEPTH - STALL_SLACK).
- Overflow: a request is dropped and err_ovf is set if accepting it would make outst exceed FIFO_DEPTH.
  - A dropped request produces no response, no RAM write, and no counter increment.
- Response:
  - Each edge: if FIFO is non-empty and mc_rs_stall=0, the head is popped into the mc_rs_* registers and mc_rs_vld is driven to 1.
  - Otherwise mc_rs_vld is driven to 0 and the data, cmd and tag outputs hold their previous values.
  - mc_rs_stall is sampled at the edge; one response is issued per non-stalled cycle.
- Latency: with FIFO empty and no stall, a request accepted at edge N has mc_rs_vld=1 after edge N+LATENCY+1.
- Simultaneous push and pop in one cycle: fifo_count is unchanged.
  - The pop takes the pre-push head.
  - Push into an empty FIFO becomes visible for pop on the next edge.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_count spans 0..FIFO_DEPTH inclusive.
- Counters: rd_cnt and wr_cnt wrap 2^32-1 -> 0. Flush requests are not counted.

Test Plan:
- Write cmd=2, vadr=0x40, data=0xDEADBEEF_0123, rtnctl=0x55, then read cmd=1 of vadr=0x40 on the next cycle, LATENCY=8:
  - rs cmd=3 with tag 0x55 appears 9 cycles after the write.
  - rs cmd=2 with data 0xDEADBEEF_0123 appears 9 cycles after the read.
- 20 back-to-back reads with rtnctl=0..19 and mc_rs_stall held at 1:
  - mc_rq_stall rises when outst reaches 13.
  - The 17th and later requests set err_ovf=1.
  - After releasing the stall, exactly 16 responses arrive with tags 0..15 in order.
- Toggle mc_rs_stall 1/0 every cycle during 10 reads:
  - a response is issued only on cycles with stall=0.
  - no response is lost or duplicated.
  - tags arrive in order.
- Read, flush, write sequence:
  - responses in order: cmd 2, 7, 3, each with its scmd echoed.
  - flush and write responses carry data=0.
- cmd=5 request: no response, err_cmd=1, rd_cnt and wr_cnt unchanged.
- Assert rst_n=0 with 6 requests in flight:
  - all outputs are 0 within the same cycle.
  - after release, no stale responses appear.
  - RAM retains previously written data (a read returns the old value).
